// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared ALU and single memory port, and counts retired instructions.
module rv32i_mc_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          TRAP_ON_SYSTEM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_branch,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        alu_sub,
    output logic        aluout_we,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        trap,
    output logic [31:0] instret,
    output logic [31:0] pc_init
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_LOAD, C_STORE, C_BRANCH, C_JALR, C_JAL,
        C_OPIMM, C_OP, C_AUIPC, C_LUI
    } class_t;

    state_t      state, state_nxt;
    class_t      cls, dec_cls;
    logic        dec_illegal;
    logic        taken;
    logic        retire;
    logic [1:0]  exec_a, exec_b;

    assign pc_init = RESET_PC;

    // Instruction class from the latched IR; funct3 screens out reserved encodings.
    always_comb begin
        dec_cls     = C_NOP;
        dec_illegal = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode[6:2])
                5'b00000: begin
                    dec_cls     = C_LOAD;
                    dec_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                end
                5'b01000: begin
                    dec_cls     = C_STORE;
                    dec_illegal = funct3[2] || (funct3[1:0] == 2'b11);
                end
                5'b11000: begin
                    dec_cls     = C_BRANCH;
                    dec_illegal = (funct3[2:1] == 2'b01);
                end
                5'b11001: begin
                    dec_cls     = C_JALR;
                    dec_illegal = (funct3 != 3'b000);
                end
                5'b11011: dec_cls = C_JAL;
                5'b00100: dec_cls = C_OPIMM;
                5'b01100: dec_cls = C_OP;
                5'b00101: dec_cls = C_AUIPC;
                5'b01101: dec_cls = C_LUI;
                5'b00011: dec_cls = C_NOP;
                5'b11100: dec_illegal = TRAP_ON_SYSTEM;
                default:  dec_illegal = 1'b1;
            endcase
        end
    end

    // Execute-stage operand selection; writeback re-drives the same pair for ALU results.
    always_comb begin
        exec_a = 2'd0;
        exec_b = 2'd1;
        case (cls)
            C_JAL, C_AUIPC: exec_a = 2'd1;
            C_LUI:          exec_a = 2'd2;
            C_OP, C_BRANCH: exec_b = 2'd0;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            cls     <= C_NOP;
            taken   <= 1'b0;
            instret <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                cls <= dec_cls;
            if (state == S_EXEC)
                taken <= alu_branch;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        alu_sub      = 1'b0;
        aluout_we    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        trap         = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal)
                    state_nxt = S_TRAP;
                else if (dec_cls == C_NOP)
                    state_nxt = S_WB;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                aluout_we = 1'b1;
                alu_a_sel = exec_a;
                alu_b_sel = exec_b;
                alu_sub   = (cls == C_BRANCH);
                state_nxt = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == C_STORE);
                if (mem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
                case (cls)
                    C_LOAD: begin
                        rf_we  = 1'b1;
                        wb_sel = 1'b1;
                    end
                    C_OP, C_OPIMM, C_LUI, C_AUIPC: begin
                        rf_we     = 1'b1;
                        alu_a_sel = exec_a;
                        alu_b_sel = exec_b;
                    end
                    C_JAL, C_JALR: begin
                        rf_we     = 1'b1;
                        alu_a_sel = 2'd1;
                        alu_b_sel = 2'd2;
                        pc_src    = 2'd1;
                    end
                    C_BRANCH: begin
                        if (taken) begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 2'd1;
                            pc_src    = 2'd2;
                        end
                    end
                    default: ;
                endcase
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_nxt = S_TRAP;
        endcase
        // Reset silences every strobe at once, including an in-flight memory request.
        if (rst) begin
            retire       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 2'd0;
            alu_a_sel    = 2'd0;
            alu_b_sel    = 2'd0;
            alu_sub      = 1'b0;
            aluout_we    = 1'b0;
            rf_we        = 1'b0;
            wb_sel       = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule
